// File: rtl/multicycle_ctrl_if.sv
// Signal bundle between the multicycle ARM controller and its datapath/memories.
// The master side is the controller; the slave side is the datapath and memory model.
interface multicycle_ctrl_if #(
   parameter int ALUCTRL_W = 2
);
   logic [19:0]          Instr;
   logic [3:0]           ALUFlags;
   logic                 MemReady;
   logic                 MemReq;
   logic                 MemWrite;
   logic                 PCWrite;
   logic                 RegWrite;
   logic                 IRWrite;
   logic                 AdrSrc;
   logic [1:0]           RegSrc;
   logic [1:0]           ALUSrcA;
   logic [1:0]           ALUSrcB;
   logic [1:0]           ResultSrc;
   logic [1:0]           ImmSrc;
   logic [ALUCTRL_W-1:0] ALUControl;
   logic [3:0]           State;

   modport master (
      input  Instr, ALUFlags, MemReady,
      output MemReq, MemWrite, PCWrite, RegWrite, IRWrite, AdrSrc,
             RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, State
   );

   modport slave (
      output Instr, ALUFlags, MemReady,
      input  MemReq, MemWrite, PCWrite, RegWrite, IRWrite, AdrSrc,
             RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, State
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle ARM control unit: instruction decode, main FSM, NZCV flag register and
// condition check, with request/ready memory handshaking.
module multicycle_ctrl #(
   parameter int ALUCTRL_W     = 2,
   parameter bit MEM_HANDSHAKE = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   multicycle_ctrl_if.master bus
);
   typedef enum logic [3:0] {
      FETCH  = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB  = 4'd4,
      MEMWR  = 4'd5, EXECR  = 4'd6, EXECI  = 4'd7, ALUWB = 4'd8, BRANCH = 4'd9
   } state_t;

   localparam logic [ALUCTRL_W-1:0] ALU_ADD = ALUCTRL_W'(0);
   localparam logic [ALUCTRL_W-1:0] ALU_SUB = ALUCTRL_W'(1);
   localparam logic [ALUCTRL_W-1:0] ALU_AND = ALUCTRL_W'(2);
   localparam logic [ALUCTRL_W-1:0] ALU_ORR = ALUCTRL_W'(3);
   localparam logic [ALUCTRL_W-1:0] ALU_EOR = ALUCTRL_W'(4);

   state_t               state_q, state_d;
   logic [3:0]           flags_q, flags_d;
   logic                 condexr_q, condexr_d;

   logic [1:0]           op;
   logic [3:0]           cmd, cond, rd;
   logic                 i_bit, s_bit, u_bit;
   logic                 rdy, condex_now, nw_eff;
   logic                 nowrite, legal, upd_cv, s_eff;
   logic [ALUCTRL_W-1:0] alu_cmd, alu_sel;
   logic                 memreq, irwrite, pcwrite, memwrite, regw, adrsrc;
   logic [1:0]           alusrca, alusrcb, resultsrc;
   logic                 unused_rn;

   // Instr holds bits [31:12] of the instruction, so field positions are offset by 12.
   assign cond      = bus.Instr[19:16];
   assign op        = bus.Instr[15:14];
   assign i_bit     = bus.Instr[13];
   assign cmd       = bus.Instr[12:9];
   assign u_bit     = bus.Instr[11];
   assign s_bit     = bus.Instr[8];
   assign rd        = bus.Instr[3:0];
   assign unused_rn = ^bus.Instr[7:4];

   assign rdy = bus.MemReady | ~MEM_HANDSHAKE;

   function automatic logic cond_check(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cy, v;
      {n, z, cy, v} = f;
      case (c)
         4'b0000: cond_check = z;
         4'b0001: cond_check = ~z;
         4'b0010: cond_check = cy;
         4'b0011: cond_check = ~cy;
         4'b0100: cond_check = n;
         4'b0101: cond_check = ~n;
         4'b0110: cond_check = v;
         4'b0111: cond_check = ~v;
         4'b1000: cond_check = cy & ~z;
         4'b1001: cond_check = ~cy | z;
         4'b1010: cond_check = (n == v);
         4'b1011: cond_check = (n != v);
         4'b1100: cond_check = ~z & (n == v);
         4'b1101: cond_check = z | (n != v);
         4'b1110: cond_check = 1'b1;
         default: cond_check = 1'b0;
      endcase
   endfunction

   assign condex_now = cond_check(cond, flags_q);

   // Cmd decode; CMP keeps NoWrite set and forces the S bit so it always updates flags.
   always_comb begin
      alu_cmd = ALU_ADD;
      nowrite = 1'b1;
      legal   = 1'b0;
      upd_cv  = 1'b0;
      s_eff   = s_bit;
      case (cmd)
         4'b0100: begin legal = 1'b1; nowrite = 1'b0; upd_cv = 1'b1; end
         4'b0010: begin alu_cmd = ALU_SUB; legal = 1'b1; nowrite = 1'b0; upd_cv = 1'b1; end
         4'b0000: begin alu_cmd = ALU_AND; legal = 1'b1; nowrite = 1'b0; end
         4'b1100: begin alu_cmd = ALU_ORR; legal = 1'b1; nowrite = 1'b0; end
         4'b0001: if (ALUCTRL_W == 3) begin
            alu_cmd = ALU_EOR; legal = 1'b1; nowrite = 1'b0;
         end
         4'b1010: if (ALUCTRL_W == 3) begin
            alu_cmd = ALU_SUB; legal = 1'b1; upd_cv = 1'b1; s_eff = 1'b1;
         end
         default: ;
      endcase
   end

   // Memory instructions reuse the Cmd bit positions for P/U/B/W, so NoWrite only applies to data processing.
   assign nw_eff = (op == 2'b00) ? nowrite : 1'b0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= FETCH;
         flags_q   <= 4'b0000;
         condexr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         flags_q   <= flags_d;
         condexr_q <= condexr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      flags_d   = flags_q;
      condexr_d = condexr_q;
      memreq    = 1'b0;
      irwrite   = 1'b0;
      pcwrite   = 1'b0;
      memwrite  = 1'b0;
      regw      = 1'b0;
      adrsrc    = 1'b0;
      alusrca   = 2'b00;
      alusrcb   = 2'b00;
      resultsrc = 2'b00;
      alu_sel   = ALU_ADD;
      case (state_q)
         FETCH: begin
            memreq    = 1'b1;
            alusrca   = 2'b01;
            alusrcb   = 2'b10;
            resultsrc = 2'b10;
            irwrite   = rdy;
            pcwrite   = rdy;
            if (rdy) state_d = DECODE;
         end
         DECODE: begin
            alusrca   = 2'b01;
            alusrcb   = 2'b10;
            resultsrc = 2'b10;
            condexr_d = condex_now;
            case (op)
               2'b01:   state_d = MEMADR;
               2'b00:   state_d = i_bit ? EXECI : EXECR;
               2'b10:   state_d = BRANCH;
               default: state_d = FETCH;
            endcase
         end
         MEMADR: begin
            alusrcb = 2'b01;
            alu_sel = u_bit ? ALU_ADD : ALU_SUB;
            state_d = s_bit ? MEMRD : MEMWR;
         end
         MEMRD: begin
            memreq = 1'b1;
            adrsrc = 1'b1;
            if (rdy) state_d = MEMWB;
         end
         MEMWB: begin
            resultsrc = 2'b01;
            regw      = 1'b1;
            state_d   = FETCH;
         end
         MEMWR: begin
            memreq   = 1'b1;
            adrsrc   = 1'b1;
            memwrite = condexr_q;
            if (rdy) state_d = FETCH;
         end
         EXECR, EXECI: begin
            alusrcb = (state_q == EXECI) ? 2'b01 : 2'b00;
            alu_sel = alu_cmd;
            state_d = ALUWB;
            if (condexr_q && s_eff && legal) begin
               flags_d[3:2] = bus.ALUFlags[3:2];
               if (upd_cv) flags_d[1:0] = bus.ALUFlags[1:0];
            end
         end
         ALUWB: begin
            regw    = 1'b1;
            state_d = FETCH;
         end
         BRANCH: begin
            alusrca   = 2'b10;
            alusrcb   = 2'b01;
            resultsrc = 2'b10;
            pcwrite   = condexr_q;
            state_d   = FETCH;
         end
         default: state_d = FETCH;
      endcase
      if (regw && (rd == 4'hF)) pcwrite = condexr_q & ~nw_eff;
   end

   // Strobes are gated by reset so a write or request cannot leak while reset is held.
   assign bus.MemReq     = memreq & reset;
   assign bus.IRWrite    = irwrite & reset;
   assign bus.PCWrite    = pcwrite & reset;
   assign bus.MemWrite   = memwrite & reset;
   assign bus.RegWrite   = regw & condexr_q & ~nw_eff & reset;
   assign bus.AdrSrc     = adrsrc;
   assign bus.ALUSrcA    = alusrca;
   assign bus.ALUSrcB    = alusrcb;
   assign bus.ResultSrc  = resultsrc;
   assign bus.ALUControl = alu_sel;
   assign bus.ImmSrc     = op;
   assign bus.RegSrc     = {op == 2'b01, op == 2'b10};
   assign bus.State      = state_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: three configurations checked one at a time against an
// instruction-level reference model, with directed and random instruction streams.
module tb_multicycle_ctrl;
   typedef struct packed {
      logic       memreq, memwrite, pcwrite, regwrite, irwrite, adrsrc;
      logic [1:0] regsrc, alusrca, alusrcb, resultsrc, immsrc;
      logic [2:0] aluctrl;
      logic [3:0] state;
   } outs_t;

   typedef struct packed {
      logic [2:0] alu;
      logic       nw, legal, cv, s;
   } dec_t;

   logic        clk = 1'b0;
   logic [2:0]  rst_n = 3'b111;
   logic [19:0] instr_v;
   logic [3:0]  flags_v;
   logic        ready_v;
   int          sel;
   outs_t       obs;
   logic [3:0]  m_flags;
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   multicycle_ctrl_if #(.ALUCTRL_W(2)) ifa ();
   multicycle_ctrl_if #(.ALUCTRL_W(3)) ifb ();
   multicycle_ctrl_if #(.ALUCTRL_W(3)) ifc ();

   assign ifa.Instr = instr_v;  assign ifa.ALUFlags = flags_v;  assign ifa.MemReady = ready_v;
   assign ifb.Instr = instr_v;  assign ifb.ALUFlags = flags_v;  assign ifb.MemReady = ready_v;
   assign ifc.Instr = instr_v;  assign ifc.ALUFlags = flags_v;  assign ifc.MemReady = ready_v;

   multicycle_ctrl #(.ALUCTRL_W(2), .MEM_HANDSHAKE(1'b1)) dut_a (.clk(clk), .reset(rst_n[0]), .bus(ifa));
   multicycle_ctrl #(.ALUCTRL_W(3), .MEM_HANDSHAKE(1'b1)) dut_b (.clk(clk), .reset(rst_n[1]), .bus(ifb));
   multicycle_ctrl #(.ALUCTRL_W(3), .MEM_HANDSHAKE(1'b0)) dut_c (.clk(clk), .reset(rst_n[2]), .bus(ifc));

   always_comb begin
      case (sel)
         1: obs = {ifb.MemReq, ifb.MemWrite, ifb.PCWrite, ifb.RegWrite, ifb.IRWrite, ifb.AdrSrc,
                   ifb.RegSrc, ifb.ALUSrcA, ifb.ALUSrcB, ifb.ResultSrc, ifb.ImmSrc,
                   ifb.ALUControl, ifb.State};
         2: obs = {ifc.MemReq, ifc.MemWrite, ifc.PCWrite, ifc.RegWrite, ifc.IRWrite, ifc.AdrSrc,
                   ifc.RegSrc, ifc.ALUSrcA, ifc.ALUSrcB, ifc.ResultSrc, ifc.ImmSrc,
                   ifc.ALUControl, ifc.State};
         default: obs = {ifa.MemReq, ifa.MemWrite, ifa.PCWrite, ifa.RegWrite, ifa.IRWrite, ifa.AdrSrc,
                   ifa.RegSrc, ifa.ALUSrcA, ifa.ALUSrcB, ifa.ResultSrc, ifa.ImmSrc,
                   1'b0, ifa.ALUControl, ifa.State};
      endcase
   end

   function automatic int cur_w();
      return (sel == 0) ? 2 : 3;
   endfunction

   function automatic bit cur_hs();
      return (sel != 2);
   endfunction

   // Condition table grouped in pairs: odd codes are the inverse of the even code below them.
   function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cf, v, r;
      n = f[3]; z = f[2]; cf = f[1]; v = f[0];
      case (c[3:1])
         3'd0: r = z;
         3'd1: r = cf;
         3'd2: r = n;
         3'd3: r = v;
         3'd4: r = cf & ~z;
         3'd5: r = (n == v);
         3'd6: r = ~z & (n == v);
         default: r = 1'b1;
      endcase
      if (c[0]) r = ~r;
      if (c == 4'hF) r = 1'b0;
      return r;
   endfunction

   function automatic dec_t decode(input logic [19:0] ins, input int w);
      dec_t d;
      logic [3:0] c;
      c = ins[12:9];
      d = '{alu: 3'd0, nw: 1'b1, legal: 1'b0, cv: 1'b0, s: ins[8]};
      if (c == 4'b0100)                 d = '{alu: 3'd0, nw: 1'b0, legal: 1'b1, cv: 1'b1, s: ins[8]};
      else if (c == 4'b0010)            d = '{alu: 3'd1, nw: 1'b0, legal: 1'b1, cv: 1'b1, s: ins[8]};
      else if (c == 4'b0000)            d = '{alu: 3'd2, nw: 1'b0, legal: 1'b1, cv: 1'b0, s: ins[8]};
      else if (c == 4'b1100)            d = '{alu: 3'd3, nw: 1'b0, legal: 1'b1, cv: 1'b0, s: ins[8]};
      else if (w == 3 && c == 4'b0001)  d = '{alu: 3'd4, nw: 1'b0, legal: 1'b1, cv: 1'b0, s: ins[8]};
      else if (w == 3 && c == 4'b1010)  d = '{alu: 3'd1, nw: 1'b1, legal: 1'b1, cv: 1'b1, s: 1'b1};
      return d;
   endfunction

   function automatic outs_t exp_out(input int st, input logic [19:0] ins, input logic cx,
                                     input logic rdy, input int w);
      outs_t o;
      dec_t  d;
      logic  nw;
      d  = decode(ins, w);
      nw = (ins[15:14] == 2'b00) ? d.nw : 1'b0;
      o  = '0;
      o.state  = 4'(st);
      o.immsrc = ins[15:14];
      o.regsrc = {ins[15:14] == 2'b01, ins[15:14] == 2'b10};
      case (st)
         0: begin o.memreq = 1; o.alusrca = 2'b01; o.alusrcb = 2'b10; o.resultsrc = 2'b10;
                  o.irwrite = rdy; o.pcwrite = rdy; end
         1: begin o.alusrca = 2'b01; o.alusrcb = 2'b10; o.resultsrc = 2'b10; end
         2: begin o.alusrcb = 2'b01; o.aluctrl = ins[11] ? 3'd0 : 3'd1; end
         3: begin o.memreq = 1; o.adrsrc = 1; end
         4: begin o.resultsrc = 2'b01; o.regwrite = cx & ~nw;
                  if (ins[3:0] == 4'hF) o.pcwrite = cx & ~nw; end
         5: begin o.memreq = 1; o.adrsrc = 1; o.memwrite = cx; end
         6: begin o.alusrcb = 2'b00; o.aluctrl = d.alu; end
         7: begin o.alusrcb = 2'b01; o.aluctrl = d.alu; end
         8: begin o.regwrite = cx & ~nw; if (ins[3:0] == 4'hF) o.pcwrite = cx & ~nw; end
         9: begin o.alusrca = 2'b10; o.alusrcb = 2'b01; o.resultsrc = 2'b10; o.pcwrite = cx; end
         default: ;
      endcase
      return o;
   endfunction

   function automatic outs_t rst_exp();
      outs_t o;
      o = exp_out(0, instr_v, 1'b0, 1'b0, cur_w());
      o.memreq = 0; o.irwrite = 0; o.pcwrite = 0; o.regwrite = 0; o.memwrite = 0;
      return o;
   endfunction

   task automatic chk(input outs_t exp, input string tag);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s dut=%0d observed=%h (state %0d) expected=%h (state %0d)",
                tag, sel, obs, obs.state, exp, exp.state);
      end
   endtask

   task automatic reset_cycles(input int n);
      rst_n[sel] = 1'b0;
      m_flags = 4'b0000;
      repeat (n) begin
         ready_v = 1'($urandom);
         instr_v = 20'($urandom);
         @(negedge clk);
         chk(rst_exp(), "reset_hold");
         @(posedge clk); #1;
      end
      rst_n[sel] = 1'b1;
   endtask

   // One whole instruction: the expected state walk is derived from the instruction class,
   // then each cycle is compared. fw/mw are wait cycles inserted in FETCH and MEMRD/MEMWR.
   task automatic run_instr(input logic [19:0] ins, input int fw, input int mw, input bit hold0,
                            input bit rnd_flags, input logic [3:0] fl, input bit abort_wr);
      int   seq[$];
      int   st, n;
      bit   waitable;
      logic rdy, cx;
      dec_t d;
      d = decode(ins, cur_w());
      case (ins[15:14])
         2'b01:   if (ins[8]) seq = '{0, 1, 2, 3, 4}; else seq = '{0, 1, 2, 5};
         2'b00:   seq = '{0, 1, ins[13] ? 7 : 6, 8};
         2'b10:   seq = '{0, 1, 9};
         default: seq = '{0, 1};
      endcase
      cx = 1'b0;
      instr_v = ins;
      foreach (seq[k]) begin
         st = seq[k];
         waitable = (st == 0) || (st == 3) || (st == 5);
         n = (waitable && cur_hs()) ? (((st == 0) ? fw : mw) + 1) : 1;
         for (int j = 0; j < n; j++) begin
            if (hold0)                     ready_v = 1'b0;
            else if (waitable && cur_hs()) ready_v = (j == n - 1);
            else                           ready_v = 1'($urandom);
            flags_v = rnd_flags ? 4'($urandom) : fl;
            rdy = ready_v | ~cur_hs();
            @(negedge clk);
            chk(exp_out(st, ins, cx, rdy, cur_w()), "cycle");
            if (abort_wr && st == 5) begin
               #2 rst_n[sel] = 1'b0;
               m_flags = 4'b0000;
               #1 chk(rst_exp(), "reset_in_memwr");
               @(posedge clk); #1;
               return;
            end
            @(posedge clk); #1;
            if (st == 1) cx = cond_ok(ins[19:16], m_flags);
            if ((st == 6 || st == 7) && cx && d.s && d.legal) begin
               m_flags[3:2] = flags_v[3:2];
               if (d.cv) m_flags[1:0] = flags_v[1:0];
            end
         end
      end
   endtask

   function automatic logic [19:0] rand_instr();
      logic [19:0] r;
      r = 20'($urandom);
      if ($urandom_range(1, 0) == 1) begin
         case ($urandom_range(5, 0))
            0: r[12:9] = 4'b0100;
            1: r[12:9] = 4'b0010;
            2: r[12:9] = 4'b0000;
            3: r[12:9] = 4'b1100;
            4: r[12:9] = 4'b0001;
            default: r[12:9] = 4'b1010;
         endcase
      end
      if ($urandom_range(3, 0) == 0) r[3:0] = 4'hF;
      if ($urandom_range(2, 0) == 0) r[19:16] = 4'hE;
      return r;
   endfunction

   initial begin
      instr_v = '0;
      flags_v = '0;
      ready_v = 1'b0;
      sel     = 0;
      m_flags = '0;
      #2 rst_n = 3'b000;
      @(posedge clk); #1;

      // Configuration A: 2-bit ALU control, handshake on.
      reset_cycles(3);
      run_instr(20'hE0811, 0, 0, 0, 1, 4'h0, 0);      // ADD R1, S=0
      run_instr(20'hE5912, 0, 2, 0, 1, 4'h0, 0);      // LDR, two MEMRD waits
      run_instr(20'hE0500, 0, 0, 0, 0, 4'b0110, 0);   // SUBS giving zero
      run_instr(20'h0A000, 0, 0, 0, 1, 4'h0, 0);      // BEQ taken
      run_instr(20'hE0500, 0, 0, 0, 0, 4'b0010, 0);   // SUBS nonzero
      run_instr(20'h0A000, 0, 0, 0, 1, 4'h0, 0);      // BEQ not taken
      run_instr(20'hE1500, 0, 0, 0, 0, 4'b0100, 0);   // CMP is illegal here
      run_instr(20'h0A000, 0, 0, 0, 1, 4'h0, 0);      // flags must not have moved
      run_instr(20'hE5801, 1, 2, 0, 1, 4'h0, 1);      // STR cut short by reset in MEMWR
      reset_cycles(1);
      for (int i = 0; i < 40; i++)
         run_instr(rand_instr(), $urandom_range(2, 0), $urandom_range(2, 0), 0, 1, 4'h0, 0);
      rst_n[0] = 1'b0;

      // Configuration B: 3-bit ALU control, handshake on.
      sel = 1;
      reset_cycles(2);
      run_instr(20'hE1500, 0, 0, 0, 0, 4'b0100, 0);   // CMP R0,R0
      run_instr(20'h0A000, 0, 0, 0, 1, 4'h0, 0);      // BEQ taken after CMP
      run_instr(20'hE0221, 0, 0, 0, 1, 4'h0, 0);      // EOR
      for (int i = 0; i < 40; i++)
         run_instr(rand_instr(), $urandom_range(2, 0), $urandom_range(2, 0), 0, 1, 4'h0, 0);
      rst_n[1] = 1'b0;

      // Configuration C: 3-bit ALU control, MemReady ignored.
      sel = 2;
      reset_cycles(2);
      run_instr(20'hE5801, 0, 0, 1, 1, 4'h0, 0);      // STR with MemReady held low
      run_instr(20'hE5912, 0, 0, 1, 1, 4'h0, 0);      // LDR with MemReady held low
      for (int i = 0; i < 30; i++)
         run_instr(rand_instr(), 0, 0, 0, 1, 4'h0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
